// File: rtl/result_demux_pkg.sv
// Shared definitions for the ALU write-back result demux: destination codes,
// default sizes and the destination decode helper.
package result_demux_pkg;

  localparam int unsigned DEFAULT_WIDTH = 32;
  localparam int unsigned DEFAULT_DEPTH = 4;

  localparam logic [1:0] DEST_NONE = 2'd0;
  localparam logic [1:0] DEST_ACC  = 2'd1;
  localparam logic [1:0] DEST_FIFO = 2'd2;
  localparam logic [1:0] DEST_BOTH = 2'd3;

  typedef struct packed {
    logic acc_we;
    logic push_req;
  } dest_dec_t;

  // Turns a qualified destination code into accumulator-write / FIFO-push strobes.
  function automatic dest_dec_t dest_decode(input logic valid, input logic [1:0] sel);
    dest_dec_t dec;
    dec = '0;
    if (valid) begin
      case (sel)
        DEST_NONE: dec = '0;
        DEST_ACC: begin
          dec.acc_we   = 1'b1;
          dec.push_req = 1'b0;
        end
        DEST_FIFO: begin
          dec.acc_we   = 1'b0;
          dec.push_req = 1'b1;
        end
        DEST_BOTH: begin
          dec.acc_we   = 1'b1;
          dec.push_req = 1'b1;
        end
        default: dec = '0;
      endcase
    end
    return dec;
  endfunction

endpackage

// File: rtl/result_demux_if.sv
// Bus between the ALU/output stage and the result demux: result input side and
// the accumulator / output-FIFO side.
interface result_demux_if
  import result_demux_pkg::*;
#(
  parameter int unsigned WIDTH = DEFAULT_WIDTH,
  parameter int unsigned CNT_W = $clog2(DEFAULT_DEPTH) + 1
) ();

  logic [WIDTH-1:0] alu_result;
  logic [1:0]       sel_dest;
  logic             result_valid;
  logic             out_ready;

  logic [WIDTH-1:0] acc_out;
  logic [WIDTH-1:0] output_number;
  logic             out_valid;
  logic             fifo_full;
  logic [CNT_W-1:0] count;
  logic             overflow_err;

  // Master drives results and downstream ready; slave is the demux.
  modport master (
    output alu_result,
    output sel_dest,
    output result_valid,
    output out_ready,
    input  acc_out,
    input  output_number,
    input  out_valid,
    input  fifo_full,
    input  count,
    input  overflow_err
  );

  modport slave (
    input  alu_result,
    input  sel_dest,
    input  result_valid,
    input  out_ready,
    output acc_out,
    output output_number,
    output out_valid,
    output fifo_full,
    output count,
    output overflow_err
  );

endinterface

// File: rtl/result_fifo.sv
// Show-ahead synchronous FIFO: data_o presents the entry at the read pointer
// (zero when empty); a push while full is accepted only if a pop frees a slot.
module result_fifo #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned DEPTH = 4,
  parameter int unsigned CNT_W = 3
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             push_i,
  input  logic [WIDTH-1:0] data_i,
  input  logic             pop_i,
  output logic [WIDTH-1:0] data_o,
  output logic             full_o,
  output logic             empty_o,
  output logic [CNT_W-1:0] count_o
);

  localparam int unsigned PtrW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PtrW-1:0]  wr_ptr_q, wr_ptr_d;
  logic [PtrW-1:0]  rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             empty, full;
  logic             do_push, do_pop;

  assign empty   = (count_q == '0);
  assign full    = (count_q == CNT_W'(DEPTH));
  assign do_pop  = pop_i && !empty;
  assign do_push = push_i && (!full || do_pop);

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    // Power-of-two depth lets the pointers wrap by natural overflow.
    if (do_push) wr_ptr_d = wr_ptr_q + PtrW'(1);
    if (do_pop)  rd_ptr_d = rd_ptr_q + PtrW'(1);
    unique case ({do_push, do_pop})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  always_ff @(posedge clk_i) begin
    if (do_push) mem_q[wr_ptr_q] <= data_i;
  end

  assign data_o  = empty ? '0 : mem_q[rd_ptr_q];
  assign full_o  = full;
  assign empty_o = empty;
  assign count_o = count_q;

  count_in_range_a : assert property (@(posedge clk_i) disable iff (rst_i)
    count_q <= CNT_W'(DEPTH));

endmodule

// File: rtl/result_demux.sv
// Routes each ALU result to the accumulator feedback register, the output FIFO,
// both or neither; dropped FIFO pushes latch a sticky overflow flag.
module result_demux
  import result_demux_pkg::*;
#(
  parameter int unsigned WIDTH = DEFAULT_WIDTH,
  parameter int unsigned DEPTH = DEFAULT_DEPTH,
  parameter int unsigned CNT_W = $clog2(DEFAULT_DEPTH) + 1
) (
  input  logic          clk,
  input  logic          rst,
  result_demux_if.slave bus_io
);

  dest_dec_t        dec;
  logic [WIDTH-1:0] acc_q, acc_d;
  logic             ovf_q, ovf_d;
  logic             fifo_empty, fifo_full;
  logic             pop, push_drop;

  assign dec = dest_decode(bus_io.result_valid, bus_io.sel_dest);
  assign pop = !fifo_empty && bus_io.out_ready;
  // A full FIFO still takes the push when the same-cycle pop frees a slot.
  assign push_drop = dec.push_req && fifo_full && !pop;

  always_comb begin
    acc_d = acc_q;
    ovf_d = ovf_q | push_drop;
    if (dec.acc_we) acc_d = bus_io.alu_result;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      acc_q <= '0;
      ovf_q <= 1'b0;
    end else begin
      acc_q <= acc_d;
      ovf_q <= ovf_d;
    end
  end

  result_fifo #(
    .WIDTH (WIDTH),
    .DEPTH (DEPTH),
    .CNT_W (CNT_W)
  ) u_fifo (
    .clk_i   (clk),
    .rst_i   (rst),
    .push_i  (dec.push_req),
    .data_i  (bus_io.alu_result),
    .pop_i   (pop),
    .data_o  (bus_io.output_number),
    .full_o  (fifo_full),
    .empty_o (fifo_empty),
    .count_o (bus_io.count)
  );

  assign bus_io.acc_out      = acc_q;
  assign bus_io.out_valid    = !fifo_empty;
  assign bus_io.fifo_full    = fifo_full;
  assign bus_io.overflow_err = ovf_q;

endmodule
